// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst and response encodings plus a size helper.
package axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int AXI_ID_W  = 4;
    localparam int AXI_LEN_W = 8;

    // AxSIZE encoding for a full-width beat of data_w bits.
    function automatic logic [2:0] size_from_width(input int unsigned data_w);
        logic [2:0]  sz;
        int unsigned bytes;
        sz    = 3'd0;
        bytes = data_w / 8;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                sz = 3'(i);
            end
        end
        return sz;
    endfunction

endpackage

// File: rtl/axi_interface_if.sv
// AXI4 signal bundle with master/slave modports split into write and read halves.
interface axi_interface_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport wr_mst (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport rd_mst (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport wr_slv (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

    modport rd_slv (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_line_burst_master.sv
// Cache-line AXI master: one refill (read burst) or writeback (write burst) at a time,
// with a shared line buffer used for read assembly and write serialisation.
module axi_line_burst_master
    import axi_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int BEATS     = 16,
    parameter int LINE_BITS = BEATS * DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 resp_err,
    axi_interface_if.wr_mst      write_mst,
    axi_interface_if.rd_mst      read_mst
);

    localparam int                BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int                OFFS_W     = $clog2(LINE_BITS / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFFS_W) - ADDR_W'(1));

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5,
        RESP    = 3'd6
    } line_master_state_e;

    line_master_state_e state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               err_q, err_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               b_done_q, b_done_d;
    logic [DATA_W-1:0]  line_q [BEATS];
    logic [DATA_W-1:0]  line_d [BEATS];

    logic in_wr_beats;
    logic w_hs;
    logic b_hs;
    logic aw_seen;
    logic w_seen;

    assign in_wr_beats = (state_q == WR_ADDR) || (state_q == WR_DATA);
    assign w_hs        = write_mst.wvalid && write_mst.wready;
    assign b_hs        = write_mst.bvalid && write_mst.bready;

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = err_q;

        read_mst.arid    = '0;
        read_mst.araddr  = addr_q;
        read_mst.arlen   = 8'(BEATS - 1);
        read_mst.arsize  = size_from_width(DATA_W);
        read_mst.arburst = AXI_BURST_INCR;
        read_mst.arvalid = (state_q == RD_ADDR);
        read_mst.rready  = (state_q == RD_DATA);

        write_mst.awid    = '0;
        write_mst.awaddr  = addr_q;
        write_mst.awlen   = 8'(BEATS - 1);
        write_mst.awsize  = size_from_width(DATA_W);
        write_mst.awburst = AXI_BURST_INCR;
        // AW and beat 0 are offered together; each drops once its own handshake is seen.
        write_mst.awvalid = (state_q == WR_ADDR) && !aw_done_q;
        write_mst.wvalid  = ((state_q == WR_ADDR) && !w_done_q) || (state_q == WR_DATA);
        write_mst.wdata   = line_q[beat_q];
        write_mst.wstrb   = '1;
        write_mst.wlast   = (beat_q == LAST_BEAT);
        // A slave may return B alongside the final W beat, so bready opens on that beat too.
        write_mst.bready  = (state_q == WR_RESP)
                         || (in_wr_beats && write_mst.wvalid && write_mst.wlast && !b_done_q);
    end

    always_comb begin
        resp_rdata = '0;
        for (int k = 0; k < BEATS; k++) begin
            resp_rdata[k*DATA_W +: DATA_W] = line_q[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        b_done_d  = b_done_q;
        line_d    = line_q;
        aw_seen   = aw_done_q || (write_mst.awvalid && write_mst.awready);
        w_seen    = w_done_q || w_hs;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr & ALIGN_MASK;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_done_d  = 1'b0;
                    if (req_write) begin
                        state_d = WR_ADDR;
                        for (int k = 0; k < BEATS; k++) begin
                            line_d[k] = req_wdata[k*DATA_W +: DATA_W];
                        end
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (read_mst.arready) begin
                    state_d = RD_DATA;
                    beat_d  = '0;
                end
            end
            RD_DATA: begin
                if (read_mst.rvalid) begin
                    line_d[beat_q] = read_mst.rdata;
                    beat_d         = beat_q + 1'b1;
                    if (read_mst.rresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (read_mst.rlast != (beat_q == LAST_BEAT)) begin
                        err_d = 1'b1;
                    end
                    if (read_mst.rlast || (beat_q == LAST_BEAT)) begin
                        state_d = RESP;
                    end
                end
            end
            WR_ADDR, WR_DATA: begin
                if (b_hs) begin
                    b_done_d = 1'b1;
                    if (write_mst.bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                end
                if (state_q == WR_ADDR) begin
                    if (aw_seen && w_seen) begin
                        beat_d = BEAT_W'(1);
                        if (LAST_BEAT == '0) begin
                            state_d = (b_done_q || b_hs) ? RESP : WR_RESP;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end else begin
                        aw_done_d = aw_seen;
                        w_done_d  = w_seen;
                    end
                end else if (w_hs) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = (b_done_q || b_hs) ? RESP : WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (write_mst.bvalid) begin
                    if (write_mst.bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            for (int k = 0; k < BEATS; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            b_done_q  <= b_done_d;
            for (int k = 0; k < BEATS; k++) begin
                line_q[k] <= line_d[k];
            end
        end
    end

endmodule

// File: tb/tb_axi_line_burst_master.sv
// Directed bench for axi_line_burst_master with an in-line AXI slave and word-addressed memory.
module tb_axi_line_burst_master;
    import axi_pkg::*;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 64;
    localparam int BEATS     = 16;
    localparam int LINE_BITS = BEATS * DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [LINE_BITS-1:0] req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [LINE_BITS-1:0] resp_rdata;
    logic                 resp_err;

    axi_interface_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(AXI_ID_W)) axi ();

    axi_line_burst_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BEATS(BEATS), .LINE_BITS(LINE_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .write_mst(axi), .read_mst(axi)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem [longint];

    logic [63:0] last_araddr, last_awaddr;
    logic [7:0]  last_arlen, last_awlen;
    logic [4:0]  last_ar_fmt, last_aw_fmt;
    logic [7:0]  last_wstrb;
    logic [7:0]  last_ids;

    task automatic check_eq(input string tag, input logic [LINE_BITS-1:0] got,
                            input logic [LINE_BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input longint idx);
        return mem.exists(idx) ? mem[idx] : 64'(idx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    endtask

    task automatic do_refill(input logic [63:0] addr, input int err_beat, input int last_beat,
                             input bit gaps, input int hold,
                             output logic [LINE_BITS-1:0] line, output logic err);
        logic [63:0]          base;
        logic [LINE_BITS-1:0] held;
        logic                 busy_bad;
        int                   k;
        int                   guard;
        busy_bad  = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0; req_addr = '1;
        check_eq("ar_latency", axi.arvalid, 1'b1);
        last_araddr = axi.araddr;
        last_arlen  = axi.arlen;
        last_ar_fmt = {axi.arsize, axi.arburst};
        last_ids    = {4'h0, axi.arid};
        base        = axi.araddr >> 3;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        k = 0; guard = 0;
        while (k <= last_beat && guard < 100) begin
            guard++;
            if (req_ready) busy_bad = 1'b1;
            if (gaps && (guard % 3 == 0)) begin
                axi.rvalid = 1'b0;
                tick();
                continue;
            end
            if (!axi.rready) busy_bad = 1'b1;
            axi.rvalid = 1'b1;
            axi.rdata  = mem_rd(base + 64'(k));
            axi.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            axi.rlast  = (k == last_beat);
            tick();
            k++;
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        check_eq("rd_beats", k, last_beat + 1);
        check_eq("rd_done_latency", resp_valid, 1'b1);
        held       = resp_rdata;
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (!resp_valid || req_ready) busy_bad = 1'b1;
            tick();
        end
        if (hold > 0) check_eq("rd_hold_data", resp_rdata, held);
        check_eq("rd_busy_ready", busy_bad, 1'b0);
        line = resp_rdata;
        err  = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq("rd_back_idle", {req_ready, resp_valid, resp_err}, 3'b100);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [LINE_BITS-1:0] data,
                            input logic [1:0] bresp, input bit gaps, input bit b_same,
                            input int rst_beat, output logic err);
        logic [63:0]          base;
        logic [15:0]          wlast_seen;
        logic [LINE_BITS-1:0] sent;
        int                   k;
        int                   guard;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        check_eq("aw_w_together", {axi.awvalid, axi.wvalid}, 2'b11);
        last_awaddr = axi.awaddr;
        last_awlen  = axi.awlen;
        last_aw_fmt = {axi.awsize, axi.awburst};
        last_wstrb  = axi.wstrb;
        last_ids    = {axi.awid, 4'h0};
        base        = axi.awaddr >> 3;
        sent = '0; wlast_seen = '0; k = 0; guard = 0;
        axi.awready = 1'b1;
        while (k < BEATS && guard < 100) begin
            guard++;
            if (gaps && k > 0 && (guard % 4 == 0)) begin
                axi.wready = 1'b0;
                tick();
                continue;
            end
            if (k == rst_beat) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_valids_drop",
                         {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, resp_valid}, 6'b0);
                idle_slave();
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                check_eq("rst_idle_ready", {req_ready, resp_valid}, 2'b10);
                err = 1'b0;
                return;
            end
            sent[k*DATA_W +: DATA_W] = axi.wdata;
            wlast_seen[k]            = axi.wlast;
            mem[base + 64'(k)]       = axi.wdata;
            axi.wready = 1'b1;
            if (k == BEATS - 1 && b_same) begin
                check_eq("bready_on_last_w", axi.bready, 1'b1);
                axi.bvalid = 1'b1;
                axi.bresp  = bresp;
            end
            tick();
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
            k++;
        end
        check_eq("wr_beats", k, BEATS);
        if (!b_same) begin
            tick();
            check_eq("bready_wr_resp", {axi.bready, resp_valid}, 2'b10);
            axi.bvalid = 1'b1; axi.bresp = bresp;
            tick();
            axi.bvalid = 1'b0; axi.bresp = 2'b00;
        end
        check_eq("wr_resp_valid", resp_valid, 1'b1);
        check_eq("wlast_pos", wlast_seen, 16'h8000);
        check_eq("wdata_line", sent, data);
        err = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq("wr_back_idle", {req_ready, resp_valid, resp_err}, 3'b100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1);
    end

    initial begin
        logic [LINE_BITS-1:0] line, exp1, wline, wline2;
        logic                 err;

        idle_slave();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs",
                 {req_ready, resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready},
                 8'b1000_0000);
        check_eq("rst_rdata", resp_rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < BEATS; k++) begin
            exp1[k*DATA_W +: DATA_W]   = 64'h0246_8000 + 64'(k);
            wline[k*DATA_W +: DATA_W]  = 64'hA5A5_0000 + 64'(k);
            wline2[k*DATA_W +: DATA_W] = 64'h5A00_0000_0000_0000 + 64'(k);
        end

        // Aligned refill from preloaded memory.
        do_refill(64'h1234_0008, -1, 15, 1'b0, 0, line, err);
        check_eq("t1_araddr", last_araddr, 64'h1234_0000);
        check_eq("t1_arlen", last_arlen, 8'd15);
        check_eq("t1_arsize_burst", last_ar_fmt, 5'b011_01);
        check_eq("t1_arid", last_ids, 8'h00);
        check_eq("t1_line", line, exp1);
        check_eq("t1_err", err, 1'b0);

        // Writeback then read back.
        do_write(64'h80, wline, 2'b00, 1'b0, 1'b0, -1, err);
        check_eq("t2_awaddr", last_awaddr, 64'h80);
        check_eq("t2_awlen", last_awlen, 8'd15);
        check_eq("t2_awsize_burst", last_aw_fmt, 5'b011_01);
        check_eq("t2_wstrb", last_wstrb, 8'hFF);
        check_eq("t2_awid", last_ids, 8'h00);
        check_eq("t2_werr", err, 1'b0);
        do_refill(64'h80, -1, 15, 1'b0, 0, line, err);
        check_eq("t2_readback", line, wline);
        check_eq("t2_rerr", err, 1'b0);

        // Backpressure on both directions, B together with last W, held completion.
        do_write(64'h100, wline2, 2'b00, 1'b1, 1'b1, -1, err);
        check_eq("t3_werr", err, 1'b0);
        do_refill(64'h100, -1, 15, 1'b1, 5, line, err);
        check_eq("t3_readback", line, wline2);
        check_eq("t3_rerr", err, 1'b0);

        // Error responses are sticky per transaction and clear on the next one.
        do_refill(64'h200, 7, 15, 1'b0, 0, line, err);
        check_eq("t4_rresp_err", err, 1'b1);
        check_eq("t4_rresp_beat7", line[7*DATA_W +: DATA_W], 64'h47);
        do_refill(64'h200, -1, 15, 1'b0, 0, line, err);
        check_eq("t4_err_cleared", err, 1'b0);
        do_write(64'h300, wline, 2'b10, 1'b0, 1'b0, -1, err);
        check_eq("t4_bresp_err", err, 1'b1);
        do_write(64'h380, wline, 2'b10, 1'b0, 1'b1, -1, err);
        check_eq("t4_bresp_same_cycle_err", err, 1'b1);

        // Early rlast on beat 9.
        do_refill(64'h400, -1, 9, 1'b0, 0, line, err);
        check_eq("t5_early_rlast_err", err, 1'b1);
        check_eq("t5_beat9", line[9*DATA_W +: DATA_W], 64'h89);

        // Reset during write beat 5, then a clean refill.
        do_write(64'h500, wline, 2'b00, 1'b0, 1'b0, 5, err);
        check_eq("t6_rdata_cleared", resp_rdata, '0);
        do_refill(64'h1234_0008, -1, 15, 1'b0, 0, line, err);
        check_eq("t6_line", line, exp1);
        check_eq("t6_err", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
